// File: rtl/cart_sdram_arb.sv
// Shares one SDRAM port between buffered ioctl download writes (priority) and cart reads.
// Optional one-entry read cache enabled by defining ARB_RDCACHE_EN.
module cart_sdram_arb #(
    parameter int unsigned AW         = 25,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          ioctl_wait,
    output logic          wr_overflow,
    input  logic          cart_rd,
    input  logic [19:0]   cart_a,
    output logic [7:0]    cart_d,
    output logic          cart_valid,
    output logic [5:0]    cart_pages,
    output logic          sd_req,
    output logic          sd_we,
    output logic [AW-1:0] sd_addr,
    output logic [7:0]    sd_din,
    input  logic [7:0]    sd_dout,
    input  logic          sd_ack
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FullCnt = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

    state_e        state_q;
    logic [AW-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [7:0]    fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic          dl_q, rd_pend_q;
    logic [19:0]   rd_addr_q;

    logic full, empty, push, pop, rd_ack, dl_rise, issue_rd, resp_ff, hit_resp;
    logic cache_hit;
    logic [7:0] cache_rdata;

    assign full     = (count_q == FullCnt);
    assign empty    = (count_q == '0);
    assign pop      = (state_q == StWr) && sd_ack;
    // A full FIFO still accepts a write in the same cycle its head retires.
    assign push     = ioctl_wr && (!full || pop);
    assign count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
    assign rd_ack   = (state_q == StRd) && sd_ack;
    assign dl_rise  = ioctl_download && !dl_q;
    assign issue_rd = (state_q == StIdle) && empty && rd_pend_q && !ioctl_download;
    // An SDRAM read completion owns cart_d this cycle; other responses wait via rd_pend.
    assign resp_ff  = ioctl_download && (cart_rd || rd_pend_q) && !rd_ack;
    assign hit_resp = cache_hit && !rd_ack;

`ifdef ARB_RDCACHE_EN
    logic        cache_vld_q, fill_ok_q;
    logic [19:0] cache_tag_q;
    logic [7:0]  cache_data_q;

    assign cache_hit   = cart_rd && !ioctl_download && !push && cache_vld_q &&
                         (cart_a == cache_tag_q);
    assign cache_rdata = cache_data_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cache_vld_q  <= 1'b0;
            fill_ok_q    <= 1'b0;
            cache_tag_q  <= '0;
            cache_data_q <= '0;
        end else begin
            if (issue_rd) fill_ok_q <= 1'b1;
            // A write landing during a read makes the returned data unsafe to cache.
            if (push) begin
                cache_vld_q <= 1'b0;
                fill_ok_q   <= 1'b0;
            end else if (rd_ack && fill_ok_q) begin
                cache_vld_q  <= 1'b1;
                cache_tag_q  <= sd_addr[19:0];
                cache_data_q <= sd_dout;
            end
        end
    end
`else
    assign cache_hit   = 1'b0;
    assign cache_rdata = 8'h00;
`endif

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= ioctl_addr;
            fifo_data_q[wr_ptr_q] <= ioctl_dout;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dl_q        <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            ioctl_wait  <= 1'b0;
            wr_overflow <= 1'b0;
            cart_d      <= '0;
            cart_valid  <= 1'b0;
            cart_pages  <= '0;
            sd_req      <= 1'b0;
            sd_we       <= 1'b0;
            sd_addr     <= '0;
            sd_din      <= '0;
        end else begin
            dl_q       <= ioctl_download;
            count_q    <= count_d;
            ioctl_wait <= (count_d == FullCnt);
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);

            if (dl_rise) begin
                wr_overflow <= 1'b0;
                cart_pages  <= '0;
            end
            if (ioctl_wr && !push) wr_overflow <= 1'b1;
            if (push) cart_pages <= ioctl_addr[19:14];

            cart_valid <= 1'b0;
            if (rd_ack) begin
                cart_d     <= sd_dout;
                cart_valid <= 1'b1;
            end else if (resp_ff) begin
                cart_d     <= 8'hFF;
                cart_valid <= 1'b1;
            end else if (hit_resp) begin
                cart_d     <= cache_rdata;
                cart_valid <= 1'b1;
            end

            if (resp_ff || hit_resp) begin
                rd_pend_q <= 1'b0;
            end else if (cart_rd) begin
                rd_pend_q <= 1'b1;
                rd_addr_q <= cart_a;
            end else if (issue_rd) begin
                rd_pend_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (!empty) begin
                        state_q <= StWr;
                        sd_req  <= 1'b1;
                        sd_we   <= 1'b1;
                        sd_addr <= fifo_addr_q[rd_ptr_q];
                        sd_din  <= fifo_data_q[rd_ptr_q];
                    end else if (issue_rd) begin
                        state_q <= StRd;
                        sd_req  <= 1'b1;
                        sd_we   <= 1'b0;
                        sd_addr <= AW'(rd_addr_q);
                    end
                end
                StWr, StRd: begin
                    if (sd_ack) begin
                        state_q <= StIdle;
                        sd_req  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    sd_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cart_sdram_arb.sv
// Directed + randomized bench for cart_sdram_arb with a behavioural SDRAM and memory model.
module tb_cart_sdram_arb;

    localparam int AW = 25;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          ioctl_download, ioctl_wr, ioctl_wait, wr_overflow;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          cart_rd, cart_valid;
    logic [19:0]   cart_a;
    logic [7:0]    cart_d;
    logic [5:0]    cart_pages;
    logic          sd_req, sd_we, sd_ack;
    logic [AW-1:0] sd_addr;
    logic [7:0]    sd_din, sd_dout;
    logic          rsp_ack, man_ack;

    assign sd_ack = rsp_ack | man_ack;

    cart_sdram_arb #(.AW(AW), .FIFO_DEPTH(4)) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait), .wr_overflow(wr_overflow), .cart_rd(cart_rd),
        .cart_a(cart_a), .cart_d(cart_d), .cart_valid(cart_valid), .cart_pages(cart_pages),
        .sd_req(sd_req), .sd_we(sd_we), .sd_addr(sd_addr), .sd_din(sd_din),
        .sd_dout(sd_dout), .sd_ack(sd_ack)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic       we;
        int         addr;
        logic [7:0] data;
    } xact_t;

    xact_t      xq[$];
    logic [7:0] vq[$];
    logic [7:0] sdram[int];
    int         checks = 0;
    int         errors = 0;
    int         req_cnt = 0;
    int         lat_cfg = 3;
    bit         rand_lat = 1'b0;
    bit         rsp_en = 1'b1;

    function automatic logic [7:0] dflt(input int a);
        return a[7:0] ^ 8'h5C;
    endfunction

    function automatic int n_reads();
        int n = 0;
        foreach (xq[i]) if (!xq[i].we) n++;
        return n;
    endfunction

    // SDRAM model: acks a request after a configurable latency and logs completed accesses.
    initial begin
        int wcnt = 0;
        int cur_lat = 3;
        int a;
        rsp_ack = 1'b0;
        sd_dout = 8'h00;
        forever begin
            @(posedge clk_sys);
            #2;
            rsp_ack = 1'b0;
            if (!rsp_en || !sd_req) begin
                wcnt = 0;
            end else begin
                if (wcnt == 0) cur_lat = rand_lat ? int'($urandom_range(1, 5)) : lat_cfg;
                wcnt++;
                if (wcnt == cur_lat) begin
                    rsp_ack = 1'b1;
                    a = int'(sd_addr);
                    if (sd_we) begin
                        sdram[a] = sd_din;
                        xq.push_back('{1'b1, a, sd_din});
                    end else begin
                        sd_dout = sdram.exists(a) ? sdram[a] : dflt(a);
                        xq.push_back('{1'b0, a, sd_dout});
                    end
                end
            end
        end
    end

    initial begin
        logic req_prev = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (cart_valid) vq.push_back(cart_d);
            if (sd_req && !req_prev) req_cnt++;
            req_prev = sd_req;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_xq(input int n, input int budget, input string tag);
        int k = 0;
        while (xq.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, xq.size(), n);
    endtask

    task automatic wait_vq(input int n, input int budget, input string tag);
        int k = 0;
        while (vq.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, vq.size(), n);
    endtask

    task automatic do_read(input logic [19:0] addr, input logic [7:0] expd, input string tag);
        int b = vq.size();
        cart_rd = 1'b1;
        cart_a  = addr;
        tick();
        cart_rd = 1'b0;
        wait_vq(b + 1, 60, {tag, "_timeout"});
        chk(tag, (vq.size() > b) ? vq[b] : 8'hxx, expd);
    endtask

    initial begin
        int base, b, k, idx, b_req, r0, exp1, exp2, a;
        int raddr[24];
        logic [7:0] rdat[24];
        logic [7:0] model[int];
        logic [7:0] e;

        reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
        ioctl_dout = '0; cart_rd = 1'b0; cart_a = '0; man_ack = 1'b0;
        tick(3);
        chk("reset_outs", {sd_req, sd_we, ioctl_wait, wr_overflow, cart_valid, cart_pages,
                           cart_d, sd_din}, 0);
        chk("reset_addr", sd_addr, 0);
        reset = 1'b0;
        tick();

        // Compliant HPS burst: all six writes reach SDRAM in order
        ioctl_download = 1'b1;
        tick();
        base = xq.size(); idx = 0; k = 0;
        while (idx < 6 && k < 100) begin
            if (!ioctl_wait) begin
                ioctl_wr = 1'b1; ioctl_addr = AW'(idx); ioctl_dout = 8'(8'hA0 + idx);
                idx++;
            end else begin
                ioctl_wr = 1'b0;
            end
            tick();
            k++;
        end
        ioctl_wr = 1'b0;
        wait_xq(base + 6, 100, "burst_drain");
        tick(3);
        for (int i = 0; i < 6; i++)
            chk("burst_wr", {xq[base+i].we, xq[base+i].data, xq[base+i].addr[15:0]},
                {1'b1, 8'(8'hA0 + i), 16'(i)});
        chk("burst_no_overflow", wr_overflow, 0);

        // Burst ignoring ioctl_wait: fills after 4, fifth rides a pop, sixth dropped
        base = xq.size();
        for (int i = 0; i < 6; i++) begin
            ioctl_wr = 1'b1; ioctl_addr = AW'(16 + i); ioctl_dout = 8'(8'hB0 + i);
            tick();
            if (i == 2) chk("wait_after3", ioctl_wait, 0);
            if (i == 3) chk("wait_after4", ioctl_wait, 1);
        end
        ioctl_wr = 1'b0;
        wait_xq(base + 5, 60, "ovf_drain");
        tick(10);
        chk("ovf_count", xq.size(), base + 5);
        chk("ovf_last_addr", xq[base+4].addr, 20);
        chk("overflow_set", wr_overflow, 1);

        ioctl_download = 1'b0; tick(); ioctl_download = 1'b1; tick();
        chk("ovf_clear_on_rise", wr_overflow, 0);

        // Page tracking
        base = xq.size();
        ioctl_wr = 1'b1; ioctl_addr = AW'(32'h1C000); ioctl_dout = 8'h31; tick();
        chk("pages_7", cart_pages, 7);
        ioctl_addr = AW'(32'h20000); ioctl_dout = 8'h32; tick();
        chk("pages_8", cart_pages, 8);
        ioctl_wr = 1'b0;
        wait_xq(base + 2, 40, "pages_drain");
        tick(3);
        ioctl_download = 1'b0; tick(); ioctl_download = 1'b1; tick();
        chk("pages_clr", cart_pages, 0);

        // Read during download: no SDRAM access, 0xFF next cycle
        b_req = req_cnt; b = vq.size();
        cart_rd = 1'b1; cart_a = 20'h00777; tick(); cart_rd = 1'b0;
        chk("dl_valid", cart_valid, 1);
        chk("dl_data", cart_d, 8'hFF);
        tick();
        chk("dl_valid_pulse", cart_valid, 0);
        tick(5);
        chk("dl_no_req", req_cnt, b_req);
        chk("dl_one_pulse", vq.size(), b + 1);

        // Plain SDRAM read
        ioctl_download = 1'b0; lat_cfg = 4; sdram[32'h12345] = 8'h5A; b = vq.size();
        cart_rd = 1'b1; cart_a = 20'h12345; tick(); cart_rd = 1'b0;
        chk("rd_req_lat0", sd_req, 0);
        tick();
        chk("rd_req_lat1", sd_req, 1);
        chk("rd_addr", sd_addr, 32'h0012345);
        chk("rd_we", sd_we, 0);
        wait_vq(b + 1, 20, "rd_done");
        tick(6);
        chk("rd_data", vq[b], 8'h5A);
        chk("rd_one_pulse", vq.size(), b + 1);
        chk("rd_hold", cart_d, 8'h5A);

        // Queued write beats simultaneous read; re-read during flight gives one more read
        lat_cfg = 3; base = xq.size(); b = vq.size();
        ioctl_wr = 1'b1; ioctl_addr = AW'(32'h300); ioctl_dout = 8'h77;
        cart_rd = 1'b1; cart_a = 20'h00300;
        tick();
        ioctl_wr = 1'b0; cart_rd = 1'b0;
        k = 0;
        while (!(sd_req && !sd_we) && k < 30) begin
            tick();
            k++;
        end
        chk("rd_inflight_seen", sd_req && !sd_we, 1);
        cart_rd = 1'b1; cart_a = 20'h00100; tick(); cart_rd = 1'b0;
        wait_xq(base + 3, 60, "wr_rd_drain");
        tick(15);
        chk("wr_rd_count", xq.size(), base + 3);
        chk("order0", {xq[base].we, xq[base].addr[23:0]}, {1'b1, 24'h000300});
        chk("order1", {xq[base+1].we, xq[base+1].addr[23:0]}, {1'b0, 24'h000300});
        chk("order2", {xq[base+2].we, xq[base+2].addr[23:0]}, {1'b0, 24'h000100});
        chk("rd_after_wr", vq[b], 8'h77);
        chk("rd_latest", vq[b+1], dflt(32'h100));
        chk("wr_rd_valids", vq.size(), b + 2);

        // Repeated reads, then a write in between
`ifdef ARB_RDCACHE_EN
        exp1 = 1; exp2 = 2;
`else
        exp1 = 2; exp2 = 3;
`endif
        r0 = n_reads();
        do_read(20'h00040, dflt(32'h40), "c_rd1");
        do_read(20'h00040, dflt(32'h40), "c_rd2");
        tick(3);
        chk("cache_reads", n_reads() - r0, exp1);
        base = xq.size();
        ioctl_wr = 1'b1; ioctl_addr = AW'(32'h9999); ioctl_dout = 8'h12; tick(); ioctl_wr = 1'b0;
        wait_xq(base + 1, 20, "c_wr_drain");
        tick(3);
        do_read(20'h00040, dflt(32'h40), "c_rd3");
        tick(3);
        chk("cache_inval", n_reads() - r0, exp2);

        // Reset in the middle of a write, then a stale ack
        rsp_en = 1'b0; ioctl_download = 1'b1; base = xq.size();
        ioctl_wr = 1'b1; ioctl_addr = AW'(32'h500); ioctl_dout = 8'h11; tick(); ioctl_wr = 1'b0;
        k = 0;
        while (!sd_req && k < 10) begin
            tick();
            k++;
        end
        chk("rst_req_up", sd_req, 1);
        reset = 1'b1;
        #1;
        chk("rst_async", sd_req, 0);
        tick();
        chk("rst_outs", {sd_req, sd_we, ioctl_wait, wr_overflow, cart_valid, cart_pages,
                         cart_d, sd_din}, 0);
        chk("rst_addr", sd_addr, 0);
        reset = 1'b0;
        tick();
        b_req = req_cnt;
        man_ack = 1'b1; tick(); man_ack = 1'b0;
        tick(8);
        chk("rst_stale_ack", req_cnt, b_req);
        chk("rst_no_xact", xq.size(), base);
        rsp_en = 1'b1;
        ioctl_wr = 1'b1; ioctl_addr = AW'(32'h600); ioctl_dout = 8'h22; tick(); ioctl_wr = 1'b0;
        wait_xq(base + 1, 20, "rst_fifo_drain");
        tick(10);
        chk("rst_fifo_empty", xq.size(), base + 1);
        chk("rst_fifo_entry", xq[base].addr, 32'h600);

        // Randomized compliant download, then random reads against a memory model
        rand_lat = 1'b1;
        for (int i = 0; i < 24; i++) begin
            raddr[i] = int'(32'h40000 | $urandom_range(0, 16'hFFFF));
            rdat[i]  = 8'($urandom);
        end
        base = xq.size(); idx = 0; k = 0;
        while (idx < 24 && k < 2000) begin
            if (!ioctl_wait && $urandom_range(0, 2) != 0) begin
                ioctl_wr = 1'b1; ioctl_addr = AW'(raddr[idx]); ioctl_dout = rdat[idx];
                model[raddr[idx]] = rdat[idx];
                idx++;
            end else begin
                ioctl_wr = 1'b0;
            end
            tick();
            k++;
        end
        ioctl_wr = 1'b0;
        wait_xq(base + 24, 600, "rnd_drain");
        tick(8);
        for (int i = 0; i < 24; i++)
            chk("rnd_wr", {xq[base+i].we, xq[base+i].data, xq[base+i].addr[19:0]},
                {1'b1, rdat[i], 20'(raddr[i])});
        chk("rnd_no_overflow", wr_overflow, 0);
        ioctl_download = 1'b0;
        tick(3);
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 3) == 0) a = int'(32'h90000 | $urandom_range(0, 16'hFFFF));
            else a = raddr[$urandom_range(0, 23)];
            e = model.exists(a) ? model[a] : dflt(a);
            do_read(20'(a), e, "rnd_rd");
            tick(int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
